// File: rtl/xpb_table_gen.sv
// -----------------------------------------------------------------------------
// xpb_table_gen
//
// Builds a lookup table of modular multiples: entry j = (j * B) mod N for
// j = 0 .. 2^IDX_BITS-1. The table is produced by repeated modular addition.
// Each step adds B to a running accumulator and subtracts N at most once. This
// works because both the accumulator and B are kept strictly below N.
//
// Ports
//   clk      : single clock, rising edge
//   rst      : synchronous active-high reset
//   start    : one-cycle build request, honoured only while idle
//   modulus  : N, captured when a request is accepted
//   base     : B, captured when a request is accepted
//   busy     : high while a build is running
//   done     : one-cycle pulse at the end of a build or rejected request
//   err      : one-cycle pulse with done when B >= N (also covers N = 0)
//   wr_en    : table write strobe
//   wr_addr  : index j of the entry being written
//   wr_data  : entry value (j * B) mod N
//
// Schedule
//   The request is accepted at cycle 0. Entry 0 is written at cycle 1 (INIT).
//   Each later entry takes two cycles: ADD registers the sum, and RED writes
//   the reduced value. Entry j therefore appears at cycle 1 + 2j, and done
//   follows the last write.
// -----------------------------------------------------------------------------
module xpb_table_gen #(
  parameter int W        = 1024,
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        modulus,
  input  logic [W-1:0]        base,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                wr_en,
  output logic [IDX_BITS-1:0] wr_addr,
  output logic [W-1:0]        wr_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    ADD  = 2'd2,
    RED  = 2'd3
  } state_e;

  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  state_e              state_q;
  logic [W-1:0]        n_q;
  logic [W-1:0]        b_q;
  logic [W-1:0]        acc_q;
  logic [W:0]          sum_q;
  logic [IDX_BITS-1:0] j_q;
  logic [IDX_BITS-1:0] wr_addr_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                wr_en_q;
  logic [W-1:0]        red_d;

  // The sum is below 2N, so a single conditional subtract brings it into
  // [0, N). The extra bit of the sum catches a carry out of W bits.
  function automatic logic [W-1:0] mod_reduce(input logic [W:0]   s,
                                              input logic [W-1:0] n);
    logic [W:0] n_ext;
    logic [W:0] diff;
    n_ext = {1'b0, n};
    diff  = s - n_ext;
    if (s >= n_ext) begin
      mod_reduce = diff[W-1:0];
    end else begin
      mod_reduce = s[W-1:0];
    end
  endfunction

  assign red_d = mod_reduce(sum_q, n_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      acc_q     <= '0;
      j_q       <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q <= modulus;
            b_q <= base;
            if (base >= modulus) begin
              // Reject the request. B >= N also covers N = 0.
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              // Outputs are registered, so the entry-0 write is set up here
              // and becomes visible during the INIT cycle.
              state_q   <= INIT;
              busy_q    <= 1'b1;
              wr_en_q   <= 1'b1;
              wr_addr_q <= '0;
            end
          end
        end
        INIT: begin
          acc_q   <= '0;
          j_q     <= {{(IDX_BITS-1){1'b0}}, 1'b1};
          wr_en_q <= 1'b0;
          state_q <= ADD;
        end
        ADD: begin
          sum_q     <= {1'b0, acc_q} + {1'b0, b_q};
          // Set up the strobe and address for the RED-cycle write.
          wr_en_q   <= 1'b1;
          wr_addr_q <= j_q;
          state_q   <= RED;
        end
        RED: begin
          acc_q   <= red_d;
          wr_en_q <= 1'b0;
          if (j_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            j_q     <= j_q + 1'b1;
            state_q <= ADD;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Select the write data from registered state:
  //   INIT : entry 0, which is always 0
  //   RED  : the freshly reduced sum
  //   other: the accumulator, which holds the most recently written entry
  always_comb begin
    wr_data = acc_q;
    case (state_q)
      INIT:    wr_data = '0;
      RED:     wr_data = red_d;
      default: wr_data = acc_q;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
module tb_xpb_table_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Narrow instance (W = 16)
  logic        start16;
  logic [15:0] mod16;
  logic [15:0] base16;
  logic        busy16;
  logic        done16;
  logic        err16;
  logic        wr_en16;
  logic [4:0]  wr_addr16;
  logic [15:0] wr_data16;

  // Default-width instance (W = 1024)
  logic          startw;
  logic [1023:0] modw;
  logic [1023:0] basew;
  logic          busyw;
  logic          donew;
  logic          errw;
  logic          wr_enw;
  logic [4:0]    wr_addrw;
  logic [1023:0] wr_dataw;

  int total = 0;
  int bad   = 0;

  xpb_table_gen #(.W(16), .IDX_BITS(5)) dut16 (
    .clk     (clk),
    .rst     (rst),
    .start   (start16),
    .modulus (mod16),
    .base    (base16),
    .busy    (busy16),
    .done    (done16),
    .err     (err16),
    .wr_en   (wr_en16),
    .wr_addr (wr_addr16),
    .wr_data (wr_data16)
  );

  xpb_table_gen dutw (
    .clk     (clk),
    .rst     (rst),
    .start   (startw),
    .modulus (modw),
    .base    (basew),
    .busy    (busyw),
    .done    (donew),
    .err     (errw),
    .wr_en   (wr_enw),
    .wr_addr (wr_addrw),
    .wr_data (wr_dataw)
  );

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[255:0], exp[255:0]);
    end
  endtask

  // Build on the 16-bit instance and check every cycle against (j*B) mod N.
  // pre: start was already applied in the previous cycle.
  // chain: assert start again in the done cycle.
  task automatic run16(input longint n, input longint b, input bit pre,
                       input bit chain, input longint cn, input longint cb);
    longint j;
    longint e;
    if (!pre) begin
      @(negedge clk);
      start16 = 1'b1;
      mod16   = 16'(n);
      base16  = 16'(b);
    end
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      // Extra starts and input changes during the build must be ignored.
      start16 = (c == 10 || c == 40);
      mod16   = 16'($urandom);
      base16  = 16'($urandom);
      if (c == 1) chk("busy_first", busy16, 1'b1);
      if (c == 64) begin
        chk("done_last", done16, 1'b1);
        chk("busy_last", busy16, 1'b0);
        chk("err_last", err16, 1'b0);
        chk("wr_en_last", wr_en16, 1'b0);
      end else begin
        chk("done_mid", done16, 1'b0);
        if (c % 2 == 1) begin
          j = longint'((c - 1) / 2);
          e = (j * b) % n;
          chk("wr_en_odd", wr_en16, 1'b1);
          chk("wr_addr", wr_addr16, 1024'(j));
          chk("wr_data", wr_data16, 1024'(e));
        end else begin
          chk("wr_en_even", wr_en16, 1'b0);
        end
      end
    end
    if (chain) begin
      start16 = 1'b1;
      mod16   = 16'(cn);
      base16  = 16'(cb);
    end
  endtask

  task automatic run_err(input logic [15:0] n, input logic [15:0] b);
    @(negedge clk);
    start16 = 1'b1;
    mod16   = n;
    base16  = b;
    @(negedge clk);
    start16 = 1'b0;
    chk("rej_done", done16, 1'b1);
    chk("rej_err", err16, 1'b1);
    chk("rej_busy", busy16, 1'b0);
    chk("rej_wr_en", wr_en16, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rej_after_done", done16, 1'b0);
      chk("rej_after_busy", busy16, 1'b0);
      chk("rej_after_wr_en", wr_en16, 1'b0);
    end
  endtask

  initial begin
    logic [1023:0] nw;
    logic [1023:0] bw;
    logic [1029:0] prod;
    logic [1029:0] ew;

    rst     = 1'b1;
    start16 = 1'b0;
    mod16   = '0;
    base16  = '0;
    startw  = 1'b0;
    modw    = '0;
    basew   = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", busy16, 1'b0);
    chk("rst_done", done16, 1'b0);
    chk("rst_err", err16, 1'b0);
    chk("rst_wr_en", wr_en16, 1'b0);
    chk("rst_wr_addr", wr_addr16, '0);
    chk("rst_wr_data", wr_data16, '0);
    chk("rst_busy_w", busyw, 1'b0);
    chk("rst_wr_en_w", wr_enw, 1'b0);
    rst = 1'b0;

    // N=1000, B=300; the next start arrives in the done cycle.
    run16(1000, 300, 1'b0, 1'b1, 65535, 65534);
    // Carry into bit W: entry j = 65535 - j.
    run16(65535, 65534, 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    chk("hold_65504", wr_data16, 1024'(65504));
    chk("hold_addr31", wr_addr16, 1024'(31));

    // B = 0: every entry is 0.
    run16(7, 0, 1'b0, 1'b0, 0, 0);

    // Rejected requests: B == N, and N = 0.
    run_err(16'd1000, 16'd1000);
    run_err(16'd0, 16'd0);

    // Reset at cycle 20 of a build, with start asserted alongside it.
    @(negedge clk);
    start16 = 1'b1;
    mod16   = 16'd1000;
    base16  = 16'd300;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (c == 19) begin
        chk("pre_rst_wr_en", wr_en16, 1'b1);
        chk("pre_rst_addr", wr_addr16, 1024'(9));
        chk("pre_rst_data", wr_data16, 1024'(700));
      end
      if (c == 20) begin
        rst     = 1'b1;
        start16 = 1'b1;
      end
    end
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      rst     = 1'b0;
      start16 = 1'b0;
      if (k == 0) begin
        chk("abort_addr", wr_addr16, '0);
        chk("abort_data", wr_data16, '0);
      end
      chk("abort_wr_en", wr_en16, 1'b0);
      chk("abort_done", done16, 1'b0);
      chk("abort_busy", busy16, 1'b0);
    end
    run16(1000, 300, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk("hold_300", wr_data16, 1024'(300));

    // Default width with a random 1024-bit modulus.
    for (int i = 0; i < 32; i++) begin
      nw[i*32 +: 32] = $urandom;
      bw[i*32 +: 32] = $urandom;
    end
    nw[1023] = 1'b1;
    bw = bw % nw;
    @(negedge clk);
    startw = 1'b1;
    modw   = nw;
    basew  = bw;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      startw = (c == 10 || c == 40);
      modw   = ~nw;
      basew  = ~bw;
      if (c == 64) begin
        chk("w_done", donew, 1'b1);
        chk("w_err", errw, 1'b0);
        chk("w_busy", busyw, 1'b0);
      end else if (c % 2 == 1) begin
        prod = 1030'((c - 1) / 2) * {6'b0, bw};
        ew   = prod % {6'b0, nw};
        chk("w_wr_en", wr_enw, 1'b1);
        chk("w_wr_addr", wr_addrw, 1024'((c - 1) / 2));
        chk("w_wr_data", wr_dataw, ew[1023:0]);
      end else begin
        chk("w_wr_en_even", wr_enw, 1'b0);
      end
    end
    startw = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xpb_table_gen.md
XPB_TABLE_GEN -- requirements
Module: xpb_table_gen

Interface
REQ-001: Parameter W, default 1024, operand/entry width in bits.
REQ-002: Parameter IDX_BITS, default 5, table index width; table depth 2^IDX_BITS.
REQ-003: clk  input  1  single clock; all state changes on rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: start  input  1  one-cycle request to build a table; sampled only in IDLE.
REQ-006: modulus  input  W  modulus N; sampled on the accepted start cycle.
REQ-007: base  input  W  base value B, the reduced weight of one index step; sampled on the accepted start cycle.
REQ-008: busy  output  1  high while a build is in progress.
REQ-009: done  output  1  one-cycle pulse at the end of a build or rejected build.
REQ-010: err  output  1  one-cycle pulse, coincident with done, when B >= N.
REQ-011: wr_en  output  1  table write strobe to the consuming lookup storage.
REQ-012: wr_addr  output  IDX_BITS  table index j being written.
REQ-013: wr_data  output  W  entry value (j*B) mod N.

Function
REQ-014: The block SHALL use states IDLE, INIT, ADD and RED.
REQ-015: In IDLE with start=1, the block SHALL latch N and B, set busy=1, and enter INIT at cycle 1 (start = cycle 0); if B >= N, it SHALL instead pulse done=1 and err=1 at cycle 1, keep busy=0, and remain in IDLE.
REQ-016: INIT SHALL drive wr_en=1, wr_addr=0, wr_data=0 for one cycle, clear the accumulator acc to 0, set j=1, and then enter ADD.
REQ-017: ADD SHALL register sum = acc + B at W+1 bits, with no truncation, and then enter RED; wr_en=0.
REQ-018: RED SHALL set acc = (sum >= N) ? sum - N : sum, drive wr_en=1, wr_addr=j, wr_data=that same reduced value, all in the same cycle.
REQ-019: After RED, if j = 2^IDX_BITS-1 the block SHALL return to IDLE; otherwise it SHALL increment j and enter ADD.
REQ-020: Entry j SHALL be written at cycle 1+2j; the last entry (31 at default) SHALL be written at cycle 63.
REQ-021: done SHALL pulse at the cycle after the last write (cycle 64 at default); busy SHALL be 0 in that cycle.
REQ-022: Each entry SHALL be written exactly once per build, in ascending address order, and every wr_data SHALL be < N.
REQ-023: start while busy=1 SHALL be ignored, with no effect on latched N or B; changes on modulus or base after acceptance SHALL have no effect.
REQ-024: start in the same cycle as done SHALL be accepted, because the block is in IDLE that cycle.
REQ-025: wr_addr and wr_data SHALL be don't-care when wr_en=0, but SHALL hold their last values for lint-clean, glitch-free outputs.
REQ-026: N=0 SHALL be rejected via the B >= N rule.

Reset
REQ-027: rst=1 SHALL force state to IDLE and set busy=0, done=0, err=0, wr_en=0, wr_addr=0, wr_data=0, acc=0, j=0 on the next edge.
REQ-028: rst asserted mid-build SHALL abort the build: no further wr_en pulses and no done pulse; a later start SHALL rebuild from entry 0.
REQ-029: rst SHALL take priority over start in the same cycle.

Verification
REQ-030: W=16, N=1000, B=300, start -> writes of (addr,data) (0,0),(1,300),(2,600),(3,900),(4,200), ... ,(31,300) at cycles 1,3,5,...,63; done at cycle 64, err=0.
REQ-031: W=16, N=1000, B=1000 -> done=1 and err=1 at cycle 1; no wr_en pulses; busy stays 0.
REQ-032: W=16, N=65535, B=65534 -> entry j = 65535-j, with the carry into bit W exercised; entry 31 = 65504.
REQ-033: B=0, N=7 -> all 32 entries written as 0; done at cycle 64.
REQ-034: rst pulsed at cycle 20 of a build -> no wr_en after the reset edge and no done; a new start then produces the full correct table.
REQ-035: Default W=1024 with a random 1024-bit N and B<N -> every entry matches the reference model (j*B) mod N; start pulses at cycles 10 and 40 during the build are ignored.
